nand_chain_arbiter: RTL and testbench
=====================================

NAND_CHAIN_ARBITER -- requirements
Module: nand_chain_arbiter

Interface
REQ-001 SHALL have one clock and synchronous active-high reset: clk (rising edge) and rst.
REQ-002 SHALL have parameter N_REQ, default 4: number of requesters (fixed at 4 in this revision).
REQ-003 SHALL have parameter OP_W, default 4: operand bits per requester, ordered {A,B,C,D}, A = MSB.
REQ-004 clk  in  1  system clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 req  in  4  per-requester request; held high until the matching gnt bit is seen.
REQ-007 req_data  in  16  operands; requester i uses bits [4i+3:4i] as {A,B,C,D}.
REQ-008 gnt  out  4  registered one-hot grant, high for exactly one cycle.
REQ-009 res_valid  out  1  result available.
REQ-010 res_data  out  1  chain result Q.
REQ-011 res_id  out  2  index of the requester that owns res_data.
REQ-012 res_ready  in  1  consumer accepts the result.
REQ-013 busy  out  1  high whenever state is not IDLE.
REQ-014 op_count  out  8  completed-operation counter.

Function
REQ-015 The FSM SHALL have three states: IDLE, EVAL and HOLD.
REQ-016 IDLE: on an edge with req != 0, SHALL latch the winner's operands and index, set gnt for one cycle, and go to EVAL; with req == 0, SHALL stay in IDLE.
REQ-017 Arbitration SHALL be round-robin: search starts at (ptr+1) mod 4 and ascends with wrap, where ptr is the last granted index.
REQ-018 EVAL: on the next edge SHALL register res_data = ~(~(A&B&C) & D) from the latched operands, register res_id, set res_valid, and go to HOLD.
REQ-019 HOLD: res_valid, res_data and res_id SHALL stay stable until an edge with res_ready = 1.
REQ-020 On that res_ready edge the block SHALL clear res_valid, set ptr to res_id, increment op_count, and go to IDLE.
REQ-021 Latency SHALL be fixed: gnt visible 1 cycle after the request is sampled, res_valid visible 2 cycles after.
REQ-022 Minimum issue interval SHALL be 3 cycles (IDLE, EVAL, HOLD), with res_ready held high.
REQ-023 res_ready SHALL be ignored outside HOLD.
REQ-024 req changes outside IDLE SHALL be ignored.
REQ-025 A requester whose req drops before grant SHALL NOT be granted.
REQ-026 op_count SHALL saturate at 255; no wrap.
REQ-027 gnt SHALL be all-zero in every cycle except the single cycle after an IDLE grant edge.
REQ-028 When all four requesters are continuously active, grants SHALL rotate 0,1,2,3,0,...

Reset
REQ-029 rst SHALL take priority over all other inputs at any state, including mid-EVAL or mid-HOLD.
REQ-030 On reset: state = IDLE; gnt = 0; res_valid = 0; res_data = 0; res_id = 0; busy = 0; op_count = 0; ptr = 3, so requester 0 has first priority.
REQ-031 Any in-flight result SHALL be discarded on reset, with no partial res_valid pulse.

Structure
REQ-032 Package nand_chain_pkg SHALL hold the state enum (IDLE/EVAL/HOLD), N_REQ, OP_W and the index width constant.
REQ-033 A single combinational sub-module rr_pick4 SHALL be used: inputs req[3:0] and ptr[1:0], outputs a one-hot pick and an any flag.
REQ-034 The chain expression SHALL be computed inline, with its result registered only in res_data.

Verification
REQ-035 Reset/idle: rst high 2 cycles, then req = 0 for 10 cycles -> all outputs 0, busy = 0, op_count = 0.
REQ-036 Single op: req = 0001, req_data[3:0] = 1111, res_ready = 1 -> gnt = 0001 at cycle+1; res_valid = 1, res_data = 1, res_id = 0 at cycle+2; op_count = 1.
REQ-037 Truth values: operands 0111 -> 0; 0000 -> 1; 1110 -> 1; 1101 -> 0, each checked on res_data.
REQ-038 Fairness: req = 1111 held, res_ready = 1 -> res_id sequence 0,1,2,3,0 at 3-cycle spacing.
REQ-039 Backpressure: res_ready = 0 for 5 cycles in HOLD -> res_valid, res_data and res_id stable, no new gnt; release -> IDLE next cycle.
REQ-040 Reset mid-op: rst asserted during EVAL -> next cycle res_valid = 0, state IDLE, ptr = 3; a subsequent req = 1010 grants index 1 first.

Source files
------------

// File: rtl/nand_chain_arbiter_pkg.sv
// rtl/nand_chain_arbiter_pkg.sv - shared types and constants for the NAND-chain arbiter
package nand_chain_pkg;

  localparam int N_REQ = 4;
  localparam int OP_W  = 4;
  localparam int IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2
  } state_t;

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/nand_chain_arbiter_if.sv
// rtl/nand_chain_arbiter_if.sv - request/result bus between requesters and the arbiter
interface nand_chain_arbiter_if;
  import nand_chain_pkg::*;

  logic [N_REQ-1:0]      req;
  logic [N_REQ*OP_W-1:0] req_data;
  logic [N_REQ-1:0]      gnt;
  logic                  res_valid;
  logic                  res_data;
  logic [IDX_W-1:0]      res_id;
  logic                  res_ready;
  logic                  busy;
  logic [7:0]            op_count;

  modport master (
    output req, req_data, res_ready,
    input  gnt, res_valid, res_data, res_id, busy, op_count
  );

  modport slave (
    input  req, req_data, res_ready,
    output gnt, res_valid, res_data, res_id, busy, op_count
  );

endinterface

// File: rtl/nand_chain_arbiter_rr_pick4.sv
// rtl/nand_chain_arbiter_rr_pick4.sv - combinational round-robin picker for four requesters
module rr_pick4
  import nand_chain_pkg::*;
(
  input  logic [3:0]       req,
  input  logic [IDX_W-1:0] ptr,
  output logic [3:0]       pick,
  output logic             any
);

  logic [IDX_W-1:0] idx;

  // Search begins just after the last winner; offset 4 wraps back to ptr itself.
  always_comb begin
    pick = '0;
    any  = 1'b0;
    idx  = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + IDX_W'(k);
      if (!any && req[idx]) begin
        pick[idx] = 1'b1;
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nand_chain_arbiter.sv
// rtl/nand_chain_arbiter.sv - round-robin arbiter evaluating Q = ~(~(A&B&C) & D) per grant
module nand_chain_arbiter #(
  parameter int N_REQ = 4,
  parameter int OP_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  nand_chain_arbiter_if.slave  bus
);
  import nand_chain_pkg::IDX_W;
  import nand_chain_pkg::state_t;
  import nand_chain_pkg::IDLE;
  import nand_chain_pkg::EVAL;
  import nand_chain_pkg::HOLD;
  import nand_chain_pkg::onehot_to_idx;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q;
  logic [OP_W-1:0]  ops_q;
  logic [IDX_W-1:0] id_q;
  logic [N_REQ-1:0] pick;
  logic             any;
  logic [IDX_W-1:0] pick_idx;

  rr_pick4 u_pick (
    .req  (bus.req),
    .ptr  (ptr_q),
    .pick (pick),
    .any  (any)
  );

  assign pick_idx = onehot_to_idx(pick);
  assign bus.busy = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any) state_d = EVAL;
      EVAL:    state_d = HOLD;
      HOLD:    if (bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ptr resets to 3 so requester 0 is the first candidate searched.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.gnt       <= '0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= 1'b0;
      bus.res_id    <= '0;
      bus.op_count  <= '0;
      ptr_q         <= IDX_W'(3);
      ops_q         <= '0;
      id_q          <= '0;
    end else begin
      bus.gnt <= '0;
      case (state_q)
        IDLE: begin
          if (any) begin
            bus.gnt <= pick;
            ops_q   <= bus.req_data[pick_idx*OP_W +: OP_W];
            id_q    <= pick_idx;
          end
        end
        EVAL: begin
          bus.res_data  <= ~(~(ops_q[3] & ops_q[2] & ops_q[1]) & ops_q[0]);
          bus.res_id    <= id_q;
          bus.res_valid <= 1'b1;
        end
        HOLD: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            ptr_q         <= bus.res_id;
            if (bus.op_count != 8'hFF) bus.op_count <= bus.op_count + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nand_chain_arbiter.sv
// tb/tb_nand_chain_arbiter.sv - directed self-checking bench for nand_chain_arbiter
module tb_nand_chain_arbiter;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  nand_chain_arbiter_if bus ();

  nand_chain_arbiter #(.N_REQ(4), .OP_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete operation with res_ready high; requester request drops once granted.
  task automatic do_op(input logic [3:0] mask, input logic [15:0] data,
                       input int exp_id, input logic exp_q);
    bus.req      = mask;
    bus.req_data = data;
    bus.res_ready = 1'b1;
    step();
    check("op_gnt", 16'(bus.gnt), 16'(4'b0001 << exp_id));
    check("op_busy", 16'(bus.busy), 16'd1);
    bus.req = 4'b0000;
    step();
    check("op_valid", 16'(bus.res_valid), 16'd1);
    check("op_data", 16'(bus.res_data), 16'(exp_q));
    check("op_id", 16'(bus.res_id), 16'(exp_id));
    check("op_gnt_clr", 16'(bus.gnt), 16'd0);
    step();
    check("op_done_valid", 16'(bus.res_valid), 16'd0);
    check("op_done_busy", 16'(bus.busy), 16'd0);
  endtask

  logic fair_q [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.req = '0;
    bus.req_data = '0;
    bus.res_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("rst_gnt", 16'(bus.gnt), 16'd0);
    check("rst_valid", 16'(bus.res_valid), 16'd0);
    check("rst_data", 16'(bus.res_data), 16'd0);
    check("rst_id", 16'(bus.res_id), 16'd0);
    check("rst_busy", 16'(bus.busy), 16'd0);
    check("rst_count", 16'(bus.op_count), 16'd0);

    // Single op, then truth values on requester 0, then nibble slicing on requester 2.
    do_op(4'b0001, 16'h000F, 0, 1'b1);
    check("single_count", 16'(bus.op_count), 16'd1);
    do_op(4'b0001, 16'h0007, 0, 1'b0);
    do_op(4'b0001, 16'h0000, 0, 1'b1);
    do_op(4'b0001, 16'h000E, 0, 1'b1);
    do_op(4'b0001, 16'h000D, 0, 1'b0);
    do_op(4'b0100, 16'hF7FF, 2, 1'b0);
    check("truth_count", 16'(bus.op_count), 16'd6);

    // Fairness from reset: all four held, expect 0,1,2,3,0 every 3 cycles.
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req = 4'b1111;
    bus.req_data = 16'hD0E7;
    bus.res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("fair_gnt", 16'(bus.gnt), 16'(4'b0001 << (k % 4)));
      step();
      check("fair_id", 16'(bus.res_id), 16'(k % 4));
      check("fair_data", 16'(bus.res_data), 16'(fair_q[k % 4]));
      if (k == 4) bus.req = 4'b0000;
      step();
      check("fair_idle", 16'(bus.busy), 16'd0);
    end

    // Backpressure: HOLD for 5 cycles with inputs churning, then release.
    bus.res_ready = 1'b0;
    bus.req = 4'b0001;
    bus.req_data = 16'h000F;
    step();
    check("bp_gnt", 16'(bus.gnt), 16'b0001);
    bus.req = 4'b0000;
    step();
    check("bp_valid0", 16'(bus.res_valid), 16'd1);
    bus.req = 4'b1111;
    bus.req_data = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid", 16'(bus.res_valid), 16'd1);
      check("bp_data", 16'(bus.res_data), 16'd1);
      check("bp_id", 16'(bus.res_id), 16'd0);
      check("bp_no_gnt", 16'(bus.gnt), 16'd0);
      check("bp_busy", 16'(bus.busy), 16'd1);
    end
    bus.req = 4'b0000;
    bus.res_ready = 1'b1;
    step();
    check("bp_rel_valid", 16'(bus.res_valid), 16'd0);
    check("bp_rel_busy", 16'(bus.busy), 16'd0);
    step();
    check("bp_idle_gnt", 16'(bus.gnt), 16'd0);

    // Reset during EVAL discards the result and restores ptr = 3.
    bus.req = 4'b0001;
    bus.req_data = 16'h000F;
    step();
    check("mid_gnt", 16'(bus.gnt), 16'b0001);
    rst = 1'b1;
    bus.req = 4'b0000;
    step();
    check("mid_valid", 16'(bus.res_valid), 16'd0);
    check("mid_busy", 16'(bus.busy), 16'd0);
    check("mid_gnt_clr", 16'(bus.gnt), 16'd0);
    check("mid_count", 16'(bus.op_count), 16'd0);
    rst = 1'b0;
    step();
    check("mid_no_pulse", 16'(bus.res_valid), 16'd0);
    do_op(4'b1010, 16'h00F0, 1, 1'b1);

    // Saturation: continuous ops from requester 0, one completion per 3 cycles.
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req = 4'b0001;
    bus.req_data = 16'h000F;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 3 * 254; i++) step();
    check("sat_254", 16'(bus.op_count), 16'd254);
    for (int i = 0; i < 3; i++) step();
    check("sat_255", 16'(bus.op_count), 16'd255);
    for (int i = 0; i < 6; i++) step();
    check("sat_hold", 16'(bus.op_count), 16'd255);
    bus.req = 4'b0000;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
